dmux_stream: RTL

- Parametrised, registered successor to the 1x4 combinational demultiplexer.
- Routes a W-bit input stream to one of N output channels with valid/ready handshakes and a one-entry holding slot per channel.
- Two routing modes: addressed (select port) or round-robin (internal pointer).
- Sits between a single producer and N independent consumers, e.g. distributing samples to per-lane processing.

---
 rtl/dmux_stream.sv | 102 ++++++++++
 1 files changed

// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with a one-entry slot per channel,
// addressed or round-robin routing. Define DMUX_ZERO_IDLE_EN to zero idle lanes.
module dmux_stream #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int MODE = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [SELW-1:0]   in_sel,
    output logic [N-1:0]      out_valid,
    input  logic [N-1:0]      out_ready,
    output logic [N*W-1:0]    out_data,
    output logic              drop,
    output logic [SELW-1:0]   ptr
);

    // Handshake: a word moves on any edge where valid and ready are both high;
    // in_ready never depends on in_valid, and a full slot may drain and refill
    // on the same edge.

    logic [N-1:0]    full_q, full_d;
    logic [W-1:0]    data_q [N];
    logic [W-1:0]    data_d [N];
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            drop_q, drop_d;

    logic [SELW-1:0] tgt;
    logic [N-1:0]    tgt_oh;
    logic            tgt_full;
    logic            tgt_rdy;
    logic            bad_sel;
    logic            accept;
    logic            load_en;

    // Target decode is a compare loop so an out-of-range select never indexes past N.
    always_comb begin
        tgt      = (MODE == 1) ? ptr_q : in_sel;
        bad_sel  = (MODE == 0) && (int'(in_sel) >= N);
        tgt_oh   = '0;
        tgt_full = 1'b0;
        tgt_rdy  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (tgt == SELW'(i)) begin
                tgt_oh[i] = 1'b1;
                tgt_full  = full_q[i];
                tgt_rdy   = out_ready[i];
            end
        end
    end

    assign in_ready = bad_sel || !tgt_full || tgt_rdy;
    assign accept   = in_valid && in_ready;
    assign load_en  = accept && !bad_sel;

    always_comb begin
        full_d = (full_q & ~out_ready) | (load_en ? tgt_oh : '0);
        for (int i = 0; i < N; i++) begin
            data_d[i] = (load_en && tgt_oh[i]) ? in_data : data_q[i];
        end
        ptr_d = ptr_q;
        if (MODE == 1 && load_en) begin
            ptr_d = (ptr_q == SELW'(N - 1)) ? '0 : ptr_q + 1'b1;
        end
        drop_d = accept && bad_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            ptr_q  <= '0;
            drop_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            drop_q <= drop_d;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = full_q;
    assign drop      = drop_q;
    assign ptr       = ptr_q;

    for (genvar g = 0; g < N; g++) begin : g_lane
`ifdef DMUX_ZERO_IDLE_EN
        assign out_data[g*W +: W] = full_q[g] ? data_q[g] : '0;
`else
        assign out_data[g*W +: W] = data_q[g];
`endif
    end

endmodule
